vote_session_ctrl: RTL

Session controller and booth arbiter for the four-candidate tally datapath (four 21-bit up-counters plus winner comparator). It opens and closes a voting session and clears the counters at session start. It arbitrates ballots from NUM_BOOTHS booths round-robin, at most one ballot per cycle, and drives one-hot increment pulses into the counters. At close it latches the comparator's winner once the counters have settled.

---
 rtl/vote_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/vote_session_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: shared encodings for the vote session controller.
// State codes, candidate codes, default tally width, one-hot helper.
package vote_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [1:0] CAND_A = 2'd0;
  localparam logic [1:0] CAND_B = 2'd1;
  localparam logic [1:0] CAND_C = 2'd2;
  localparam logic [1:0] CAND_D = 2'd3;

  localparam int VOTE_CNT_W = 21;

  function automatic logic [3:0] cand_onehot(input logic [1:0] c);
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (c)
      CAND_A: oh = 4'b0001;
      CAND_B: oh = 4'b0010;
      CAND_C: oh = 4'b0100;
      CAND_D: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-wide round-robin pick, first requester at/after ptr.
// Ports: req, ptr in; one-hot gnt and its index idx out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest
  // requester (lowest offset from ptr) overwrites the rest.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: session FSM + booth arbiter for the 4-way tally.
// Ports: clk/rst (sync, high); open_req/close_req session control;
//   booth_req/booth_choice in, booth_gnt out; inc/counter_rst to the
//   counters; winner_in from comparator, winner_q latched; total,
//   state_q, session_done status. With VOTE_TIMEOUT_EN defined an
//   OPEN-cycle timer adds the timed_out output.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int NUM_BOOTHS  = 4,
  parameter int CNT_W       = VOTE_CNT_W,
  parameter int MAX_VOTES   = 1000,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    open_req,
  input  logic                    close_req,
  input  logic [NUM_BOOTHS-1:0]   booth_req,
  input  logic [2*NUM_BOOTHS-1:0] booth_choice,
  output logic [NUM_BOOTHS-1:0]   booth_gnt,
  output logic [3:0]              inc,
  output logic                    counter_rst,
  input  logic [1:0]              winner_in,
  output logic [1:0]              winner_q,
  output logic [CNT_W-1:0]        total,
  output logic [1:0]              state_q,
  output logic                    session_done
`ifdef VOTE_TIMEOUT_EN
  ,
  output logic                    timed_out
`endif
);

  localparam int PW = $clog2(NUM_BOOTHS);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_VOTES);

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         arb_idx;
  logic [PW-1:0]         ptr_nxt;
  logic [NUM_BOOTHS-1:0] arb_gnt;
  logic [CNT_W-1:0]      total_nxt;
  logic [1:0]            choice;
  logic                  grant_en;
  logic                  accept;
  logic                  at_limit;
  logic                  timeout_hit;
  logic                  close_now;
  logic                  drain_last;

  rr_arbiter #(
    .N  (NUM_BOOTHS),
    .PW (PW)
  ) u_arb (
    .req (booth_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // No grants while the counters are being cleared or once full.
  assign grant_en  = (state_q == ST_OPEN) && !counter_rst
                     && (total < MAXV);
  assign booth_gnt = grant_en ? arb_gnt : '0;
  assign accept    = |(booth_req & booth_gnt);
  assign choice    = booth_choice[{arb_idx, 1'b0} +: 2];
  assign total_nxt = total + CNT_W'(1);
  assign ptr_nxt   = (arb_idx == PW'(NUM_BOOTHS - 1))
                     ? '0 : arb_idx + 1'b1;
  assign at_limit  = accept && (total_nxt == MAXV);
  assign close_now = close_req || at_limit || timeout_hit;

  assign session_done = (state_q == ST_RESULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inc         <= '0;
      counter_rst <= 1'b1;
      total       <= '0;
      winner_q    <= '0;
      rr_ptr      <= '0;
      drain_last  <= 1'b0;
    end else begin
      inc         <= '0;
      counter_rst <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_RESULT: begin
          if (open_req) begin
            state_q     <= ST_OPEN;
            total       <= '0;
            counter_rst <= 1'b1;
          end
        end
        ST_OPEN: begin
          if (accept) begin
            inc    <= cand_onehot(choice);
            total  <= total_nxt;
            rr_ptr <= ptr_nxt;
          end
          if (close_now) begin
            state_q    <= ST_DRAIN;
            drain_last <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Two cycles: the last inc lands, then the comparator settles.
          if (drain_last) begin
            state_q  <= ST_RESULT;
            winner_q <= winner_in;
          end else begin
            drain_last <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef VOTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer;
  logic          opening;

  assign opening     = ((state_q == ST_IDLE) || (state_q == ST_RESULT))
                       && open_req;
  assign timeout_hit = (state_q == ST_OPEN)
                       && (timer == TW'(TIMEOUT_CYC - 1));

  // Timer idles at zero outside OPEN so it starts from 0 on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      timed_out <= 1'b0;
    end else if (state_q == ST_OPEN) begin
      timer <= timer + 1'b1;
      if (timeout_hit) begin
        timed_out <= 1'b1;
      end
    end else begin
      timer <= '0;
      if (opening) begin
        timed_out <= 1'b0;
      end
    end
  end
`else
  // Timer not built; keep the limit parameter referenced.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

endmodule
